instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Sequencer that fetches one two-byte instruction (opcode, operand) from the memory block via the program counter and hands it to the decoder. It sits directly upstream of decode and drives the memory block's `op`, `bus_selector` and `data_word_selector` inputs while busy, consuming the memory `out` byte. When not fetching, it issues no memory operation, so other masters can use the memory block.

## Interface

- `COUNT_WIDTH`, default 16: width of the completed-fetch counter.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `fetch_en`  in  1  permits starting a new fetch.
- `flush`  in  1  synchronous abort (jump or branch taken); drops any in-flight or held instruction.
- `mem_data`  in  8  memory `out` byte.
- `mem_op`  out  memory_op_e  to memory `op`.
- `mem_bus_selector`  out  memory_bus_selector_e  to memory `bus_selector`; 1 selects PC.
- `mem_data_word_selector`  out  1  to memory `data_word_selector`; 0 selects the opcode byte, 1 selects the operand byte.
- `instr_valid`  out  1  opcode and operand are valid.
- `instr_ready`  in  1  decoder accepts the instruction.
- `opcode`  out  8  fetched byte at {PC,0}.
- `operand`  out  8  fetched byte at {PC,1}.
- `busy`  out  1  high in every state except IDLE and HOLD.
- `fetch_count`  out  COUNT_WIDTH  number of completed handshakes, modulo 2^COUNT_WIDTH.

## Operation

- Memory outputs are decoded from state (Moore):
  - IDLE: op NOP, bus 0, dws 0.
  - LO_REQ: READ, bus 1, dws 0.
  - LO_CAP: READ, bus 1, dws 0.
  - HI_REQ: READ, bus 1, dws 1.
  - HI_CAP: READ, bus 1, dws 1.
  - PC_INC: INC, bus 1, dws 0.
  - HOLD: NOP, bus 0, dws 0.
- The memory registers read data on the posedge ending a READ cycle and drives `out` only while `op` is READ. Therefore each byte needs two READ cycles:
  - REQ latches the data.
  - CAP samples `mem_data` at the closing posedge.
- State transitions:
  - IDLE → LO_REQ if `fetch_en`, else stay.
  - LO_REQ → LO_CAP → HI_REQ → HI_CAP → PC_INC → HOLD, unconditional.
  - HOLD → LO_REQ if `instr_ready && fetch_en`.
  - HOLD → IDLE if `instr_ready && !fetch_en`.
  - HOLD → stay otherwise.
- `opcode` loads `mem_data` at the posedge ending LO_CAP. `operand` loads at the posedge ending HI_CAP. Both hold until the next load.
- `instr_valid` = (state == HOLD). `opcode` and `operand` are stable for the whole time `instr_valid` is high.
- The PC advances by exactly 1 per completed fetch, via the PC_INC state. PC wrap-around is owned by the memory block and is not checked here.
- `fetch_count` increments on the posedge where `instr_valid && instr_ready`, and wraps from all-ones to 0.
- `flush` (priority below reset, above everything else):
  - Next state is IDLE. `fetch_count` is unchanged. `opcode` and `operand` keep their values.
  - If flush is sampled in PC_INC, that cycle's INC is still issued, because outputs are combinational from state.
  - If flush is sampled in HOLD, the instruction is discarded and no count increment occurs, even if `instr_ready` is high.
- `fetch_en` deasserting mid-fetch does not abort the fetch; it only prevents the next fetch from starting.

## Timing

- Reset values: state IDLE, `mem_op` NOP, `mem_bus_selector` 0, `mem_data_word_selector` 0, `instr_valid` 0, `busy` 0, `opcode` 0x00, `operand` 0x00, `fetch_count` 0.
- Reset applied mid-fetch returns to IDLE on that edge; the PC is untouched by this block.
- Latency: `fetch_en` sampled in IDLE at edge E → `instr_valid` high in the cycle after edge E+5 (6 cycles).
- Back-to-back throughput: 6 cycles per instruction with `instr_ready` held high. HOLD lasts a minimum of 1 cycle.
- `instr_ready` outside HOLD is ignored.
- No combinational path from any input to any output.

## Test plan

- Reset and idle: hold `reset`=0 for 2 cycles with `fetch_en`=1 → all outputs at reset values. After release, `mem_op` is READ on the first cycle only if `fetch_en` was sampled high at the release edge.
- Single fetch: memory PC=0, cells {0,0}=0x3A and {0,1}=0x05, `fetch_en` pulsed for 1 cycle, `instr_ready`=1.
  - Expect `instr_valid` 6 cycles after the sampling edge, with `opcode`=0x3A and `operand`=0x05.
  - Expect PC=1 and `fetch_count`=1, then return to IDLE.
- Backpressure: `instr_ready`=0 for 10 cycles in HOLD → `instr_valid`, `opcode` and `operand` stable, `mem_op`=NOP, no PC change. Raising `instr_ready` completes exactly one handshake.
- Streaming: `fetch_en`=1, `instr_ready`=1, three instructions at PC 0..2 → three valid pulses 6 cycles apart with the correct byte pairs, then PC=3 and `fetch_count`=3.
- Flush:
  - Assert in HI_REQ → IDLE next cycle, no INC issued, PC unchanged, `instr_valid` never rises.
  - Assert in HOLD with `instr_ready`=1 → no count increment.
- Counter wrap: with `COUNT_WIDTH`=2, four handshakes → `fetch_count` sequence 1,2,3,0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared memory-interface types for instruction_fetch and its environment.
//   memory_op_e           : operation code presented on the memory `op` input
//   memory_bus_selector_e : address source for the memory block (PC or data bus)
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_INC   = 2'd3
  } memory_op_e;

  typedef enum logic {
    BUS_DATA = 1'b0,
    BUS_PC   = 1'b1
  } memory_bus_selector_e;

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches one two-byte instruction (opcode, operand) from
// the memory block at the program counter and presents it to the decoder with
// a valid/ready handshake. The memory is idle (NOP) whenever no fetch is in
// progress, so other masters may use it.
//
// Ports
//   clock                  in   rising-edge clock
//   reset                  in   synchronous, active-low reset
//   fetch_en               in   permits a new fetch to start
//   flush                  in   synchronous abort; drops in-flight/held instruction
//   mem_data               in   memory `out` byte
//   mem_op                 out  memory operation
//   mem_bus_selector       out  memory address source (BUS_PC while fetching)
//   mem_data_word_selector out  0 = opcode byte, 1 = operand byte
//   instr_valid            out  opcode/operand valid (HOLD state)
//   instr_ready            in   decoder accepts the instruction
//   opcode                 out  byte at {PC,0}
//   operand                out  byte at {PC,1}
//   busy                   out  high in every state except IDLE and HOLD
//   fetch_count            out  completed handshakes, modulo 2^COUNT_WIDTH
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   flush,
  input  logic [7:0]             mem_data,
  output memory_op_e             mem_op,
  output memory_bus_selector_e   mem_bus_selector,
  output logic                   mem_data_word_selector,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [7:0]             opcode,
  output logic [7:0]             operand,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_REQ = 3'd1,
    LO_CAP = 3'd2,
    HI_REQ = 3'd3,
    HI_CAP = 3'd4,
    PC_INC = 3'd5,
    HOLD   = 3'd6
  } state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [7:0]             r_opcode;
  logic [7:0]             r_operand;
  logic [COUNT_WIDTH-1:0] r_fetch_count;
  logic                   w_handshake;

  // A flush in HOLD discards the instruction, so it never counts as accepted.
  assign w_handshake = (r_state == HOLD) && instr_ready && !flush;

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (fetch_en) w_next_state = LO_REQ;
        LO_REQ:  w_next_state = LO_CAP;
        LO_CAP:  w_next_state = HI_REQ;
        HI_REQ:  w_next_state = HI_CAP;
        HI_CAP:  w_next_state = PC_INC;
        PC_INC:  w_next_state = HOLD;
        HOLD: begin
          if (instr_ready) w_next_state = fetch_en ? LO_REQ : IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_opcode      <= 8'h00;
      r_operand     <= 8'h00;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_next_state;
      // Memory drives `out` during the CAP cycle with the byte latched in REQ.
      if (!flush && r_state == LO_CAP) r_opcode  <= mem_data;
      if (!flush && r_state == HI_CAP) r_operand <= mem_data;
      if (w_handshake) r_fetch_count <= r_fetch_count + COUNT_WIDTH'(1);
    end
  end

  // Memory controls are a pure function of state, so no input reaches an
  // output combinationally; a flush sampled in PC_INC still sees INC issued.
  always_comb begin
    mem_op                 = MEM_NOP;
    mem_bus_selector       = BUS_DATA;
    mem_data_word_selector = 1'b0;
    case (r_state)
      LO_REQ, LO_CAP: begin
        mem_op           = MEM_READ;
        mem_bus_selector = BUS_PC;
      end
      HI_REQ, HI_CAP: begin
        mem_op                 = MEM_READ;
        mem_bus_selector       = BUS_PC;
        mem_data_word_selector = 1'b1;
      end
      PC_INC: begin
        mem_op           = MEM_INC;
        mem_bus_selector = BUS_PC;
      end
      default: begin
        mem_op                 = MEM_NOP;
        mem_bus_selector       = BUS_DATA;
        mem_data_word_selector = 1'b0;
      end
    endcase
  end

  assign instr_valid = (r_state == HOLD);
  assign busy        = (r_state != IDLE) && (r_state != HOLD);
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch with a behavioural memory block model and
// a scoreboard of expected (opcode, operand) pairs.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int CW = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 fetch_en = 1'b0;
  logic                 flush = 1'b0;
  logic                 instr_ready = 1'b0;
  logic [7:0]           mem_data;
  memory_op_e           mem_op;
  memory_bus_selector_e mem_bus_selector;
  logic                 mem_data_word_selector;
  logic                 instr_valid;
  logic [7:0]           opcode;
  logic [7:0]           operand;
  logic                 busy;
  logic [CW-1:0]        fetch_count;

  always #5 clock = ~clock;

  instruction_fetch #(.COUNT_WIDTH(CW)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .fetch_en               (fetch_en),
    .flush                  (flush),
    .mem_data               (mem_data),
    .mem_op                 (mem_op),
    .mem_bus_selector       (mem_bus_selector),
    .mem_data_word_selector (mem_data_word_selector),
    .instr_valid            (instr_valid),
    .instr_ready            (instr_ready),
    .opcode                 (opcode),
    .operand                (operand),
    .busy                   (busy),
    .fetch_count            (fetch_count)
  );

  // Memory block model: registers read data at the end of a READ cycle,
  // drives `out` only while op is READ, increments PC on INC.
  logic [7:0] mem [0:511];
  logic [7:0] tb_pc;
  logic       pc_clr = 1'b1;
  logic [7:0] r_mem_out;

  always @(posedge clock) begin
    if (pc_clr) tb_pc <= 8'd0;
    else if (mem_op == MEM_INC && mem_bus_selector == BUS_PC) tb_pc <= tb_pc + 8'd1;
    if (mem_op == MEM_READ) r_mem_out <= mem[{tb_pc, mem_data_word_selector}];
  end

  assign mem_data = (mem_op == MEM_READ) ? r_mem_out : 8'h00;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [15:0]   sb_q[$];
  logic [7:0]    exp_pc = 8'd0;
  logic [CW-1:0] exp_count = '0;
  int            lat;
  logic [7:0]    saved_opcode;
  logic [7:0]    saved_operand;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    sb_q.push_back({mem[{exp_pc, 1'b0}], mem[{exp_pc, 1'b1}]});
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic check_pair(input string tag);
    logic [15:0] e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    chk({tag, "_opcode"}, {24'd0, opcode}, {24'd0, e[15:8]});
    chk({tag, "_operand"}, {24'd0, operand}, {24'd0, e[7:0]});
  endtask

  // Bounded wait for instr_valid; an expired bound shows up as a latency failure.
  task automatic wait_valid(output int l);
    l = 0;
    while (!instr_valid && l < 20) begin
      step();
      l++;
    end
  endtask

  initial begin
    mem[{8'd0, 1'b0}] = 8'h3A; mem[{8'd0, 1'b1}] = 8'h05;
    mem[{8'd1, 1'b0}] = 8'h7C; mem[{8'd1, 1'b1}] = 8'hE1;
    mem[{8'd2, 1'b0}] = 8'h11; mem[{8'd2, 1'b1}] = 8'h22;

    // Reset with fetch_en high: everything at reset values.
    reset = 1'b0; fetch_en = 1'b1;
    step(); step();
    pc_clr = 1'b0;
    chk("rst_op", 32'(mem_op), 32'(MEM_NOP));
    chk("rst_bus", 32'(mem_bus_selector), 32'd0);
    chk("rst_dws", 32'(mem_data_word_selector), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'h00);
    chk("rst_operand", 32'(operand), 32'h00);
    chk("rst_count", 32'(fetch_count), 32'd0);

    // Release with fetch_en low: stays idle.
    reset = 1'b1; fetch_en = 1'b0;
    step();
    chk("release_op", 32'(mem_op), 32'(MEM_NOP));

    // Single fetch at PC 0.
    fetch_en = 1'b1; instr_ready = 1'b1;
    push_expected();
    step();
    fetch_en = 1'b0;
    chk("single_lo_op", 32'(mem_op), 32'(MEM_READ));
    chk("single_lo_bus", 32'(mem_bus_selector), 32'(BUS_PC));
    chk("single_busy", 32'(busy), 32'd1);
    step(); step(); step();
    chk("single_hi_dws", 32'(mem_data_word_selector), 32'd1);
    step();
    chk("single_inc_op", 32'(mem_op), 32'(MEM_INC));
    lat = 1 + 4;
    step();
    chk("single_latency_valid", 32'(instr_valid), 32'd1);
    check_pair("single");
    chk("single_pc", 32'(tb_pc), 32'(exp_pc));
    chk("single_hold_busy", 32'(busy), 32'd0);
    step();
    exp_count = exp_count + 1'b1;
    chk("single_count", 32'(fetch_count), 32'(exp_count));
    chk("single_idle_valid", 32'(instr_valid), 32'd0);
    chk("single_idle_op", 32'(mem_op), 32'(MEM_NOP));

    // Backpressure at PC 1.
    fetch_en = 1'b1; instr_ready = 1'b0;
    push_expected();
    step();
    fetch_en = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd5);
    saved_opcode = opcode; saved_operand = operand;
    check_pair("bp");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_opcode_stable", 32'(opcode), 32'(saved_opcode));
      chk("bp_operand_stable", 32'(operand), 32'(saved_operand));
      chk("bp_op_nop", 32'(mem_op), 32'(MEM_NOP));
      chk("bp_pc", 32'(tb_pc), 32'(exp_pc));
      chk("bp_count_held", 32'(fetch_count), 32'(exp_count));
    end
    instr_ready = 1'b1;
    step();
    exp_count = exp_count + 1'b1;
    chk("bp_count", 32'(fetch_count), 32'(exp_count));
    step();
    chk("bp_count_once", 32'(fetch_count), 32'(exp_count));
    chk("bp_idle", 32'(instr_valid), 32'd0);

    // Flush in HI_REQ at PC 2: opcode was captured, operand was not.
    saved_operand = operand;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step(); step();
    chk("flush_hireq_state_dws", 32'(mem_data_word_selector), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_hireq_busy", 32'(busy), 32'd0);
    chk("flush_hireq_op", 32'(mem_op), 32'(MEM_NOP));
    for (int i = 0; i < 8; i++) begin
      chk("flush_hireq_novalid", 32'(instr_valid), 32'd0);
      chk("flush_hireq_noinc", 32'(mem_op == MEM_INC), 32'd0);
      step();
    end
    chk("flush_hireq_pc", 32'(tb_pc), 32'(exp_pc));
    chk("flush_hireq_opcode", 32'(opcode), 32'h11);
    chk("flush_hireq_operand", 32'(operand), 32'(saved_operand));
    chk("flush_hireq_count", 32'(fetch_count), 32'(exp_count));

    // Flush in HOLD with instr_ready high: discarded, no count.
    fetch_en = 1'b1; instr_ready = 1'b0;
    push_expected();
    step();
    fetch_en = 1'b0;
    wait_valid(lat);
    chk("flush_hold_latency", 32'(lat), 32'd5);
    check_pair("flush_hold");
    instr_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_hold_count", 32'(fetch_count), 32'(exp_count));
    chk("flush_hold_valid", 32'(instr_valid), 32'd0);
    chk("flush_hold_busy", 32'(busy), 32'd0);
    chk("flush_hold_pc", 32'(tb_pc), 32'(exp_pc));

    // Reset, restart PC at 0, then stream three instructions.
    reset = 1'b0; pc_clr = 1'b1;
    step();
    reset = 1'b1; pc_clr = 1'b0;
    exp_pc = 8'd0; exp_count = '0;
    chk("rst2_count", 32'(fetch_count), 32'd0);
    chk("rst2_opcode", 32'(opcode), 32'h00);
    mem[{8'd0, 1'b0}] = 8'hA1; mem[{8'd0, 1'b1}] = 8'hB2;
    mem[{8'd1, 1'b0}] = 8'hC3; mem[{8'd1, 1'b1}] = 8'hD4;
    mem[{8'd2, 1'b0}] = 8'hE5; mem[{8'd2, 1'b1}] = 8'hF6;
    mem[{8'd3, 1'b0}] = 8'h5A; mem[{8'd3, 1'b1}] = 8'hA5;
    fetch_en = 1'b1; instr_ready = 1'b1;
    push_expected(); push_expected(); push_expected();
    step();
    for (int i = 0; i < 3; i++) begin
      wait_valid(lat);
      chk("stream_latency", 32'(lat), 32'd5);
      check_pair("stream");
      if (i == 2) fetch_en = 1'b0;
      step();
      exp_count = exp_count + 1'b1;
      chk("stream_count", 32'(fetch_count), 32'(exp_count));
    end
    chk("stream_pc", 32'(tb_pc), 32'd3);
    chk("stream_count3", 32'(fetch_count), 32'd3);
    chk("stream_idle_busy", 32'(busy), 32'd0);
    chk("stream_idle_valid", 32'(instr_valid), 32'd0);

    // Fourth handshake wraps the 2-bit counter to 0.
    fetch_en = 1'b1;
    push_expected();
    step();
    fetch_en = 1'b0;
    wait_valid(lat);
    chk("wrap_latency", 32'(lat), 32'd5);
    check_pair("wrap");
    step();
    exp_count = exp_count + 1'b1;
    chk("wrap_count", 32'(fetch_count), 32'(exp_count));
    chk("wrap_count_zero", 32'(fetch_count), 32'd0);
    chk("wrap_pc", 32'(tb_pc), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
